// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALU function codes,
// FSM states, opcode/funct values, datapath select encodings and decode payload.
package mc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ALU_FUN_W = 6;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned OP_W      = 6;

  // ALU function codes
  localparam logic [ALU_FUN_W-1:0] ALU_ADD = 6'b000000;
  localparam logic [ALU_FUN_W-1:0] ALU_SUB = 6'b000001;
  localparam logic [ALU_FUN_W-1:0] ALU_AND = 6'b011000;
  localparam logic [ALU_FUN_W-1:0] ALU_OR  = 6'b011110;
  localparam logic [ALU_FUN_W-1:0] ALU_XOR = 6'b010110;
  localparam logic [ALU_FUN_W-1:0] ALU_NOR = 6'b010001;
  localparam logic [ALU_FUN_W-1:0] ALU_A   = 6'b011010;
  localparam logic [ALU_FUN_W-1:0] ALU_SLL = 6'b100000;
  localparam logic [ALU_FUN_W-1:0] ALU_SRL = 6'b100001;
  localparam logic [ALU_FUN_W-1:0] ALU_SRA = 6'b100011;
  localparam logic [ALU_FUN_W-1:0] ALU_EQ  = 6'b110011;
  localparam logic [ALU_FUN_W-1:0] ALU_NEQ = 6'b110001;
  localparam logic [ALU_FUN_W-1:0] ALU_LT  = 6'b110101;
  localparam logic [ALU_FUN_W-1:0] ALU_LEZ = 6'b111101;
  localparam logic [ALU_FUN_W-1:0] ALU_GEZ = 6'b111001;
  localparam logic [ALU_FUN_W-1:0] ALU_GTZ = 6'b111111;
  localparam logic [ALU_FUN_W-1:0] ALU_LUI = 6'b011011;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_EXCPT
  } state_e;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
  localparam logic [OP_W-1:0] OP_J      = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI    = 6'h0d;
  localparam logic [OP_W-1:0] OP_XORI   = 6'h0e;
  localparam logic [OP_W-1:0] OP_LUI    = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW     = 6'h23;
  localparam logic [OP_W-1:0] OP_SW     = 6'h2b;

  // R-type funct values
  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_JALR = 6'h09;
  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2a;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2b;

  // Datapath select encodings
  localparam logic [SEL_W-1:0] SRCA_PC     = 2'd0;
  localparam logic [SEL_W-1:0] SRCA_RS     = 2'd1;
  localparam logic [SEL_W-1:0] SRCA_SHAMT  = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_RT     = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_BOFF   = 2'd3;
  localparam logic [SEL_W-1:0] PCSRC_ALU   = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_AOUT  = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP  = 2'd2;
  localparam logic [SEL_W-1:0] PCSRC_EXC   = 2'd3;
  localparam logic [SEL_W-1:0] REGDST_RT   = 2'd0;
  localparam logic [SEL_W-1:0] REGDST_RD   = 2'd1;
  localparam logic [SEL_W-1:0] REGDST_RA   = 2'd2;
  localparam logic [SEL_W-1:0] M2R_ALUOUT  = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MDR     = 2'd1;
  localparam logic [SEL_W-1:0] M2R_PC      = 2'd2;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ITYPE, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_JUMPR
  } cls_e;

  // Decoded instruction payload, latched by the FSM at the end of DECODE
  typedef struct packed {
    cls_e                 cls;
    logic [ALU_FUN_W-1:0] alu_fun;
    logic                 sign;
    logic                 ext_op;
    logic                 shamt;
    logic                 link;
    logic                 ovf;
    logic                 illegal;
  } dec_t;

endpackage

// File: rtl/mc_instr_dec.sv
// Combinational instruction decoder: class, ALU function, sign mode, extension
// mode, shift/link/overflow-check attributes and illegal detection.
module mc_instr_dec
  import mc_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_t            dec
);

  logic [OP_W-1:0] op;
  logic [OP_W-1:0] funct;
  logic [4:0]      rt;
  logic            unused_fields;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];

  // Register numbers, shamt and immediate are datapath-only fields
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    dec         = '0;
    dec.cls     = CLS_RTYPE;
    dec.alu_fun = ALU_ADD;
    dec.ext_op  = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  begin dec.alu_fun = ALU_SLL; dec.shamt = 1'b1; end
          FN_SRL:  begin dec.alu_fun = ALU_SRL; dec.shamt = 1'b1; end
          FN_SRA:  begin dec.alu_fun = ALU_SRA; dec.shamt = 1'b1; end
          FN_JR:   begin dec.cls = CLS_JUMPR; dec.alu_fun = ALU_A; end
          FN_JALR: begin dec.cls = CLS_JUMPR; dec.alu_fun = ALU_A; dec.link = 1'b1; end
          FN_ADD:  begin dec.sign = 1'b1; dec.ovf = 1'b1; end
          FN_ADDU: dec.alu_fun = ALU_ADD;
          FN_SUB:  begin dec.alu_fun = ALU_SUB; dec.sign = 1'b1; dec.ovf = 1'b1; end
          FN_SUBU: dec.alu_fun = ALU_SUB;
          FN_AND:  dec.alu_fun = ALU_AND;
          FN_OR:   dec.alu_fun = ALU_OR;
          FN_XOR:  dec.alu_fun = ALU_XOR;
          FN_NOR:  dec.alu_fun = ALU_NOR;
          FN_SLT:  begin dec.alu_fun = ALU_LT; dec.sign = 1'b1; end
          FN_SLTU: dec.alu_fun = ALU_LT;
          default: dec.illegal = 1'b1;
        endcase
      end
      // Only bltz is supported in the REGIMM space
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          dec.cls = CLS_BRANCH; dec.alu_fun = ALU_LT; dec.sign = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_J:    dec.cls = CLS_JUMP;
      OP_JAL:  begin dec.cls = CLS_JUMP; dec.link = 1'b1; end
      OP_BEQ:  begin dec.cls = CLS_BRANCH; dec.alu_fun = ALU_EQ;  dec.sign = 1'b1; end
      OP_BNE:  begin dec.cls = CLS_BRANCH; dec.alu_fun = ALU_NEQ; dec.sign = 1'b1; end
      OP_BLEZ: begin dec.cls = CLS_BRANCH; dec.alu_fun = ALU_LEZ; dec.sign = 1'b1; end
      OP_BGTZ: begin dec.cls = CLS_BRANCH; dec.alu_fun = ALU_GTZ; dec.sign = 1'b1; end
      OP_ADDI: begin dec.cls = CLS_ITYPE; dec.sign = 1'b1; dec.ovf = 1'b1; end
      OP_ADDIU: dec.cls = CLS_ITYPE;
      OP_SLTI: begin dec.cls = CLS_ITYPE; dec.alu_fun = ALU_LT; dec.sign = 1'b1; end
      OP_SLTIU: begin dec.cls = CLS_ITYPE; dec.alu_fun = ALU_LT; end
      OP_ANDI: begin dec.cls = CLS_ITYPE; dec.alu_fun = ALU_AND; dec.ext_op = 1'b0; end
      OP_ORI:  begin dec.cls = CLS_ITYPE; dec.alu_fun = ALU_OR;  dec.ext_op = 1'b0; end
      OP_XORI: begin dec.cls = CLS_ITYPE; dec.alu_fun = ALU_XOR; dec.ext_op = 1'b0; end
      OP_LUI:  begin dec.cls = CLS_ITYPE; dec.alu_fun = ALU_LUI; end
      OP_LW:   dec.cls = CLS_LOAD;
      OP_SW:   dec.cls = CLS_STORE;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives ALU
// controls, datapath selects and write enables. Optional overflow trap: MC_OVF_EXCEPT_EN.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VEC = 32'h8000_0180
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [XLEN-1:0]      iInstr,
  input  logic                 iMemReady,
  input  logic                 iZ,
  input  logic                 iN,
  input  logic                 iV,
  output logic [ALU_FUN_W-1:0] oALUFun,
  output logic                 oSign,
  output logic [SEL_W-1:0]     oALUSrcA,
  output logic [SEL_W-1:0]     oALUSrcB,
  output logic                 oExtOp,
  output logic                 oIRWrite,
  output logic                 oPCWrite,
  output logic                 oMemRead,
  output logic                 oMemWrite,
  output logic                 oRegWrite,
  output logic [SEL_W-1:0]     oPCSrc,
  output logic [SEL_W-1:0]     oRegDst,
  output logic [SEL_W-1:0]     oMemToReg,
  output logic                 oIllegal,
  output logic [XLEN-1:0]      oExcVec
);

  state_e state_q, state_d;
  dec_t   dec, dec_q;
  logic   ovf_trap;
  logic   unused_flags;

  mc_instr_dec u_dec (
    .instr (iInstr),
    .dec   (dec)
  );

  assign oExcVec = EXC_VEC;

`ifdef MC_OVF_EXCEPT_EN
  assign ovf_trap     = dec_q.ovf & iV;
  assign unused_flags = iN ^ dec_q.illegal;
`else
  assign ovf_trap     = 1'b0;
  assign unused_flags = iN ^ iV ^ dec_q.ovf ^ dec_q.illegal;
`endif

  // State register; the decode is captured once, while the IR is stable in DECODE
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_RST;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) dec_q <= dec;
    end
  end

  // Next state and control outputs; flags and handshake gate enables in the same cycle
  always_comb begin
    state_d   = state_q;
    oALUFun   = ALU_ADD;
    oSign     = 1'b0;
    oALUSrcA  = SRCA_PC;
    oALUSrcB  = SRCB_RT;
    oExtOp    = 1'b0;
    oIRWrite  = 1'b0;
    oPCWrite  = 1'b0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oRegWrite = 1'b0;
    oPCSrc    = PCSRC_ALU;
    oRegDst   = REGDST_RT;
    oMemToReg = M2R_ALUOUT;
    oIllegal  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        oMemRead = 1'b1;
        oALUSrcB = SRCB_FOUR;
        if (iMemReady) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        oALUSrcB = SRCB_BOFF;
        oExtOp   = 1'b1;
        if (dec.illegal) begin
          oIllegal = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        oALUFun  = dec_q.alu_fun;
        oSign    = dec_q.sign;
        oExtOp   = dec_q.ext_op;
        oALUSrcA = dec_q.shamt ? SRCA_SHAMT : SRCA_RS;
        case (dec_q.cls)
          CLS_RTYPE: state_d = ovf_trap ? ST_EXCPT : ST_WB;
          CLS_ITYPE: begin
            oALUSrcB = SRCB_IMM;
            state_d  = ovf_trap ? ST_EXCPT : ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            oALUSrcB = SRCB_IMM;
            state_d  = ST_MEM;
          end
          // The ALU compare reports "condition true" as a non-zero result
          CLS_BRANCH: begin
            if (!iZ) begin
              oPCWrite = 1'b1;
              oPCSrc   = PCSRC_AOUT;
            end
            state_d = ST_FETCH;
          end
          CLS_JUMP: begin
            oALUSrcA = SRCA_PC;
            oPCWrite = 1'b1;
            oPCSrc   = PCSRC_JUMP;
            if (dec_q.link) begin
              oRegWrite = 1'b1;
              oMemToReg = M2R_PC;
              oRegDst   = REGDST_RA;
            end
            state_d = ST_FETCH;
          end
          CLS_JUMPR: begin
            oPCWrite = 1'b1;
            oPCSrc   = PCSRC_ALU;
            if (dec_q.link) begin
              oRegWrite = 1'b1;
              oMemToReg = M2R_PC;
              oRegDst   = REGDST_RD;
            end
            state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dec_q.cls == CLS_LOAD) oMemRead  = 1'b1;
        else                       oMemWrite = 1'b1;
        if (iMemReady) state_d = (dec_q.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        oRegWrite = 1'b1;
        oRegDst   = (dec_q.cls == CLS_RTYPE) ? REGDST_RD : REGDST_RT;
        oMemToReg = (dec_q.cls == CLS_LOAD) ? M2R_MDR : M2R_ALUOUT;
        state_d   = ST_FETCH;
      end
      ST_EXCPT: begin
        oPCWrite = 1'b1;
        oPCSrc   = PCSRC_EXC;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed instruction sequences push per-cycle
// expected control vectors; a negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;

  logic        iClk;
  logic        iRst_n;
  logic [31:0] iInstr;
  logic        iMemReady, iZ, iN, iV;
  logic [5:0]  oALUFun;
  logic        oSign;
  logic [1:0]  oALUSrcA, oALUSrcB;
  logic        oExtOp, oIRWrite, oPCWrite, oMemRead, oMemWrite, oRegWrite;
  logic [1:0]  oPCSrc, oRegDst, oMemToReg;
  logic        oIllegal;
  logic [31:0] oExcVec;

  mc_ctrl_fsm dut (
    .iClk(iClk), .iRst_n(iRst_n), .iInstr(iInstr), .iMemReady(iMemReady),
    .iZ(iZ), .iN(iN), .iV(iV),
    .oALUFun(oALUFun), .oSign(oSign), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
    .oExtOp(oExtOp), .oIRWrite(oIRWrite), .oPCWrite(oPCWrite), .oMemRead(oMemRead),
    .oMemWrite(oMemWrite), .oRegWrite(oRegWrite), .oPCSrc(oPCSrc), .oRegDst(oRegDst),
    .oMemToReg(oMemToReg), .oIllegal(oIllegal), .oExcVec(oExcVec)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [5:0] fun;
    logic       sign;
    logic [1:0] sa, sb;
    logic       ext;
    logic       irw, pcw, mr, mw, rw;
    logic [1:0] pcs, rd, m2r;
    logic       ill;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic exp_t mk(input logic [5:0] fun, input logic sign,
                              input logic [1:0] sa, input logic [1:0] sb, input logic ext,
                              input logic irw, input logic pcw, input logic mr,
                              input logic mw, input logic rw,
                              input logic [1:0] pcs, input logic [1:0] rd,
                              input logic [1:0] m2r, input logic ill);
    exp_t e;
    e = '{fun:fun, sign:sign, sa:sa, sb:sb, ext:ext, irw:irw, pcw:pcw, mr:mr,
          mw:mw, rw:rw, pcs:pcs, rd:rd, m2r:m2r, ill:ill};
    return e;
  endfunction

  exp_t  mon_e, mon_a;
  string mon_t;

  always @(negedge iClk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {oALUFun, oSign, oALUSrcA, oALUSrcB, oExtOp, oIRWrite, oPCWrite,
               oMemRead, oMemWrite, oRegWrite, oPCSrc, oRegDst, oMemToReg, oIllegal};
      n_tests++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got fun=%b sign=%b sa=%0d sb=%0d ext=%b irw=%b pcw=%b mr=%b mw=%b rw=%b pcs=%0d rd=%0d m2r=%0d ill=%b | expected fun=%b sign=%b sa=%0d sb=%0d ext=%b irw=%b pcw=%b mr=%b mw=%b rw=%b pcs=%0d rd=%0d m2r=%0d ill=%b",
                 mon_t, mon_a.fun, mon_a.sign, mon_a.sa, mon_a.sb, mon_a.ext, mon_a.irw,
                 mon_a.pcw, mon_a.mr, mon_a.mw, mon_a.rw, mon_a.pcs, mon_a.rd, mon_a.m2r,
                 mon_a.ill, mon_e.fun, mon_e.sign, mon_e.sa, mon_e.sb, mon_e.ext, mon_e.irw,
                 mon_e.pcw, mon_e.mr, mon_e.mw, mon_e.rw, mon_e.pcs, mon_e.rd, mon_e.m2r,
                 mon_e.ill);
      end
    end
  end

  // One clock cycle: drive inputs just after the edge, queue what the monitor must see
  task automatic cyc(input logic rdy, input logic z, input logic v, input exp_t e,
                     input string t);
    iMemReady = rdy;
    iZ        = z;
    iV        = v;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge iClk);
    #1;
  endtask

  exp_t E_ZERO, E_FETCH_W, E_FETCH_R, E_DEC, E_DEC_ILL;

  task automatic fetch_dec(input logic [31:0] ins, input string nm);
    iInstr = ins;
    cyc(1'b1, 1'b0, 1'b0, E_FETCH_R, {nm, " fetch"});
    cyc(1'b1, 1'b0, 1'b0, E_DEC, {nm, " decode"});
  endtask

  localparam logic [31:0] I_ADD  = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] I_LW   = 32'h8C22_0004; // lw   $2,4($1)
  localparam logic [31:0] I_SW   = 32'hAC22_0008; // sw   $2,8($1)
  localparam logic [31:0] I_BEQ  = 32'h1022_0003; // beq  $1,$2,3
  localparam logic [31:0] I_BNE  = 32'h1422_0001; // bne  $1,$2,1
  localparam logic [31:0] I_BLTZ = 32'h0420_0002; // bltz $1,2
  localparam logic [31:0] I_ADDI = 32'h2022_FFFF; // addi $2,$1,-1
  localparam logic [31:0] I_ILL  = 32'hFC00_0000; // opcode 111111
  localparam logic [31:0] I_SLL  = 32'h0002_1900; // sll  $3,$2,4
  localparam logic [31:0] I_ORI  = 32'h3422_00FF; // ori  $2,$1,0xff
  localparam logic [31:0] I_JAL  = 32'h0C00_0100; // jal  0x100
  localparam logic [31:0] I_JR   = 32'h03E0_0008; // jr   $31

  initial begin
    iRst_n = 1'b0; iInstr = 32'h0; iMemReady = 1'b0; iZ = 1'b0; iN = 1'b0; iV = 1'b0;
    E_ZERO    = '0;
    E_FETCH_W = mk(6'b000000, 0, 2'd0, 2'd1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    E_FETCH_R = mk(6'b000000, 0, 2'd0, 2'd1, 0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    E_DEC     = mk(6'b000000, 0, 2'd0, 2'd3, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    E_DEC_ILL = mk(6'b000000, 0, 2'd0, 2'd3, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1);

    @(posedge iClk);
    #1;
    n_tests++;
    if (oExcVec !== 32'h8000_0180) begin
      n_fail++;
      $display("FAIL exc_vec: got %h expected 80000180", oExcVec);
    end
    cyc(1'b1, 1'b0, 1'b0, E_ZERO, "reset held");
    iRst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, E_ZERO, "rst state after release");

    // add: 4 cycles
    fetch_dec(I_ADD, "add");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 1, 2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "add exec");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd0, 0), "add wb");

    // lw with two MEM wait cycles: 7 cycles
    fetch_dec(I_LW, "lw");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd1, 2'd2, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "lw exec");
    cyc(1'b0, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0), "lw mem wait1");
    cyc(1'b0, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0), "lw mem wait2");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0), "lw mem done");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 0), "lw wb");

    // beq taken (iZ=0) then not taken (iZ=1)
    fetch_dec(I_BEQ, "beq taken");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b110011, 1, 2'd1, 2'd0, 1, 0, 1, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0), "beq taken exec");
    fetch_dec(I_BEQ, "beq not taken");
    cyc(1'b1, 1'b1, 1'b0, mk(6'b110011, 1, 2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "beq not taken exec");

    // addi overflowing
    fetch_dec(I_ADDI, "addi ovf");
    cyc(1'b1, 1'b0, 1'b1, mk(6'b000000, 1, 2'd1, 2'd2, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "addi exec");
`ifdef MC_OVF_EXCEPT_EN
    cyc(1'b1, 1'b0, 1'b1, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0), "addi excpt");
`else
    cyc(1'b1, 1'b0, 1'b1, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 0), "addi wb");
`endif

    // illegal opcode: pulse in DECODE, straight back to FETCH
    iInstr = I_ILL;
    cyc(1'b1, 1'b0, 1'b0, E_FETCH_R, "illegal fetch");
    cyc(1'b1, 1'b0, 1'b0, E_DEC_ILL, "illegal decode");

    // sll with one FETCH wait cycle
    iInstr = I_SLL;
    cyc(1'b0, 1'b0, 1'b0, E_FETCH_W, "sll fetch wait");
    cyc(1'b1, 1'b0, 1'b0, E_FETCH_R, "sll fetch");
    cyc(1'b0, 1'b0, 1'b0, E_DEC, "sll decode");
    cyc(1'b0, 1'b0, 1'b0, mk(6'b100000, 0, 2'd2, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "sll exec");
    cyc(1'b0, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd0, 0), "sll wb");

    // ori: zero-extended immediate
    fetch_dec(I_ORI, "ori");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b011110, 0, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "ori exec");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 0), "ori wb");

    // jal, jr, bltz, bne
    fetch_dec(I_JAL, "jal");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 1, 0, 1, 0, 0, 1, 2'd2, 2'd2, 2'd2, 0), "jal exec");
    fetch_dec(I_JR, "jr");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b011010, 0, 2'd1, 2'd0, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "jr exec");
    fetch_dec(I_BLTZ, "bltz");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b110101, 1, 2'd1, 2'd0, 1, 0, 1, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0), "bltz taken exec");
    fetch_dec(I_BNE, "bne");
    cyc(1'b1, 1'b1, 1'b0, mk(6'b110001, 1, 2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "bne not taken exec");

    // sw interrupted by reset while waiting in MEM
    fetch_dec(I_SW, "sw");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd1, 2'd2, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "sw exec");
    cyc(1'b0, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0), "sw mem wait");
    iRst_n = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, E_ZERO, "reset in mem");
    cyc(1'b1, 1'b0, 1'b0, E_ZERO, "reset held in mem");
    iRst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, E_ZERO, "rst state after mid-instr reset");

    // recovery: add again
    fetch_dec(I_ADD, "add after reset");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 1, 2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0), "add2 exec");
    cyc(1'b1, 1'b0, 1'b0, mk(6'b000000, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd0, 0), "add2 wb");

    // bounded drain of the scoreboard
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge iClk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
